// File: rtl/regfile_mp_scoreboard_if.sv
// Bus bundle for the multi-port register file with its busy-bit scoreboard.
// The master side (decode/issue plus writeback) drives the read addresses,
// write ports, reservation and flush. The slave side (the register file)
// returns the read data, the per-port busy flags and the busy-bit vector.
//
// Signals:
//   rd_addr  : NRD read addresses, port k at [k*AW +: AW]
//   rd_data  : NRD read data words, port k at [k*XLEN +: XLEN]
//   rd_busy  : per read port, register still waiting on a producer
//   wr_en    : NWR write enables
//   wr_addr  : NWR write addresses
//   wr_data  : NWR write data words
//   rsv_en   : reserve request for an issued instruction
//   rsv_addr : destination register to mark busy
//   flush    : clears every busy bit
//   busy_vec : registered busy bits, one per register
interface regfile_mp_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                flush;
  logic [NREGS-1:0]    busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with a built-in busy-bit scoreboard.
// It has NRD combinational read ports and NWR write ports. A higher write
// port index has higher priority. A write in the same cycle is bypassed to
// any reader of that register. Register x0 is hardwired to zero. Each
// register has a busy bit. The bit is set when an instruction that targets
// the register issues, and cleared by its writeback or by a flush.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high; invalidates all registers and clears
//           busy bits (the storage array itself is left as it is)
//   bus   : slave side of regfile_mp_scoreboard_if (read/write/reserve)
module regfile_mp_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input logic                    clk,
  input logic                    reset,
  regfile_mp_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] invalid;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  logic [NWR-1:0]   we;
  logic [AW-1:0]    waddr [NWR];
  logic [XLEN-1:0]  wdata [NWR];

  logic [AW-1:0]    raddr [NRD];
  logic [NRD-1:0]   rhit;
  logic [XLEN-1:0]  rval  [NRD];

  // Unpack the write ports. A write to x0 is dropped here, so none of the
  // logic below has to special-case register 0 on the write side.
  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      waddr[j] = bus.wr_addr[j*AW +: AW];
      wdata[j] = bus.wr_data[j*XLEN +: XLEN];
      we[j]    = bus.wr_en[j] && (waddr[j] != '0);
    end
  end

  // Storage array. It has no reset, because the invalid bits hide stale
  // contents. The ports are visited in ascending order, so the last
  // non-blocking assignment comes from the highest-index port. That port
  // wins when several ports write the same register. Writes are held off
  // during reset so that reset has full priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j]) begin
          regs[waddr[j]] <= wdata[j];
        end
      end
    end
  end

  // Next busy state for a normal cycle (neither reset nor flush).
  // Writebacks clear their bit first. A reservation is applied afterwards,
  // so a new producer wins over a writeback to the same register in the
  // same cycle. Bit 0 is forced low because x0 is never reserved.
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) begin
        busy_next[waddr[j]] = 1'b0;
      end
    end
    if (bus.rsv_en && (bus.rsv_addr != '0)) begin
      busy_next[bus.rsv_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Valid tracking and the scoreboard state. A register that has not been
  // written since reset reads as zero. A flush drops all outstanding
  // reservations, including one requested in the same cycle, but the
  // register data is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      invalid <= '1;
      busy    <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j]) begin
          invalid[waddr[j]] <= 1'b0;
        end
      end
      if (bus.flush) begin
        busy <= '0;
      end else begin
        busy <= busy_next;
      end
    end
  end

  // Combinational read ports. The value starts from storage (or zero while
  // the register is invalid). A matching write in this cycle then overrides
  // it, again with the highest port index winning. The same match also
  // hides the busy bit, because the writeback satisfies the reservation for
  // this reader.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      raddr[k] = bus.rd_addr[k*AW +: AW];
      rhit[k]  = 1'b0;
      rval[k]  = invalid[raddr[k]] ? '0 : regs[raddr[k]];
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j] == raddr[k])) begin
          rhit[k] = 1'b1;
          rval[k] = wdata[j];
        end
      end
      if (raddr[k] == '0) begin
        rval[k] = '0;
      end
      bus.rd_data[k*XLEN +: XLEN] = rval[k];
      bus.rd_busy[k]              = busy[raddr[k]] && !rhit[k];
    end
  end

  assign bus.busy_vec = busy;

endmodule
